end_frame_request_gen_module: RTL and testbench

END_FRAME_REQUEST_GEN_MODULE -- requirements
Module: end_frame_request_gen_module

---
 rtl/end_frame_pkg.sv | 15 +
 rtl/end_frame_request_gen_module.sv | 116 +++++++++++
 tb/tb_end_frame_request_gen_module.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/end_frame_pkg.sv
// Shared state encoding and default timing for the end-of-frame request generator.
package end_frame_pkg;

   localparam logic [9:0]  DEF_LINES_PER_FRAME = 10'd480;
   localparam int          DEF_HOLDOFF_CYCLES  = 48;
   localparam logic [15:0] DEF_TIMEOUT_CYCLES  = 16'd50000;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_ACTIVE  = 2'd1;
   localparam state_t ST_REQUEST = 2'd2;
   localparam state_t ST_HOLDOFF = 2'd3;

endpackage

// File: rtl/end_frame_request_gen_module.sv
// Counts lines of a frame and issues a one-cycle end-of-frame request to the
// downstream reset/diode block, followed by a holdoff window.
//
//   state    | meaning
//   IDLE     | waiting for frame_start_i; results of last frame held
//   ACTIVE   | counting line strobes, gap timer watching for a stall
//   REQUEST  | request output high for this single cycle
//   HOLDOFF  | HOLDOFF_CYCLES cycles with all inputs ignored
module end_frame_request_gen_module
   import end_frame_pkg::*;
#(
   parameter logic [9:0]  LINES_PER_FRAME = DEF_LINES_PER_FRAME,
   parameter int          HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
   parameter logic [15:0] TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
   input  logic       clk_200MHz_i,
   input  logic       reset,
   input  logic       frame_start_i,
   input  logic       line_strobe_i,
   output logic       reset_after_end_frame_request_out,
   output logic       frame_active_o,
   output logic [9:0] line_count_o,
   output logic       frame_error_o
);

   localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

   state_t            state_q, state_d;
   logic [9:0]        line_q, line_d;
   logic [15:0]       gap_q, gap_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              err_q, err_d;
   logic              req_q, req_d;
   logic              active_q, active_d;

   always_comb begin
      state_d = state_q;
      line_d  = line_q;
      gap_d   = gap_q;
      hold_d  = hold_q;
      err_d   = err_q;
      req_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (frame_start_i) begin
               state_d = ST_ACTIVE;
               line_d  = '0;
               gap_d   = '0;
               err_d   = 1'b0;
            end
         end
         ST_ACTIVE: begin
            // A restart inside a frame aborts it; the coincident strobe is lost.
            if (frame_start_i) begin
               state_d = ST_REQUEST;
               err_d   = 1'b1;
               req_d   = 1'b1;
            end else if (line_strobe_i) begin
               line_d = line_q + 10'd1;
               gap_d  = '0;
               if (line_q == LINES_PER_FRAME - 10'd1) begin
                  state_d = ST_REQUEST;
                  err_d   = 1'b0;
                  req_d   = 1'b1;
               end
            end else if (gap_q == TIMEOUT_CYCLES - 16'd2) begin
               gap_d   = TIMEOUT_CYCLES - 16'd1;
               state_d = ST_REQUEST;
               err_d   = 1'b1;
               req_d   = 1'b1;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         ST_REQUEST: begin
            state_d = ST_HOLDOFF;
            hold_d  = '0;
         end
         ST_HOLDOFF: begin
            if (hold_q == HOLD_W'(HOLDOFF_CYCLES - 1)) begin
               state_d = ST_IDLE;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      active_d = (state_d == ST_ACTIVE);
   end

   always_ff @(posedge clk_200MHz_i) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         line_q   <= '0;
         gap_q    <= '0;
         hold_q   <= '0;
         err_q    <= 1'b0;
         req_q    <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         line_q   <= line_d;
         gap_q    <= gap_d;
         hold_q   <= hold_d;
         err_q    <= err_d;
         req_q    <= req_d;
         active_q <= active_d;
      end
   end

   assign reset_after_end_frame_request_out = req_q;
   assign frame_active_o                    = active_q;
   assign line_count_o                      = line_q;
   assign frame_error_o                     = err_q;

endmodule

// File: tb/tb_end_frame_request_gen_module.sv
// Directed-scenario bench: a cycle-level frame model checked every cycle, plus
// hand-computed pins at the cycles where the behaviour is easiest to reason about.
module tb_end_frame_request_gen_module;

   localparam int L = 4;
   localparam int H = 8;
   localparam int T = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       strobe = 1'b0;
   logic       req;
   logic       act;
   logic [9:0] cnt;
   logic       err;

   always #5 clk = ~clk;

   end_frame_request_gen_module #(
      .LINES_PER_FRAME(10'(L)),
      .HOLDOFF_CYCLES (H),
      .TIMEOUT_CYCLES (16'(T))
   ) dut (
      .clk_200MHz_i                     (clk),
      .reset                            (rst),
      .frame_start_i                    (start),
      .line_strobe_i                    (strobe),
      .reset_after_end_frame_request_out(req),
      .frame_active_o                   (act),
      .line_count_o                     (cnt),
      .frame_error_o                    (err)
   );

   int nvec  = 0;
   int nfail = 0;
   bit chk_en = 1'b0;

   // Model: cycle index of the cycle now in progress, frame bookkeeping in plain counters.
   int cyc       = 0;
   bit m_open    = 1'b0;
   int m_cnt     = 0;
   int m_err     = 0;
   int m_quiet   = 0;
   int m_req_at  = -100;
   int m_free_at = 0;

   task automatic end_frame(input int prev, input int e);
      m_open    = 1'b0;
      m_err     = e;
      m_req_at  = prev + 1;
      m_free_at = prev + 1 + H + 1;
   endtask

   always @(posedge clk) begin
      int prev;
      prev = cyc;
      cyc  = cyc + 1;
      if (rst) begin
         m_open = 1'b0; m_cnt = 0; m_err = 0; m_quiet = 0;
         m_req_at = -100; m_free_at = 0;
      end else if (m_open) begin
         if (start) end_frame(prev, 1);
         else if (strobe) begin
            m_cnt++;
            m_quiet = 0;
            if (m_cnt == L) end_frame(prev, 0);
         end else begin
            m_quiet++;
            if (m_quiet == T - 1) end_frame(prev, 1);
         end
      end else if (prev >= m_free_at && start) begin
         m_open = 1'b1; m_cnt = 0; m_err = 0; m_quiet = 0;
      end
   end

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
      nvec++;
      if (got !== want) begin
         nfail++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("request", 16'(req), 16'(cyc == m_req_at));
         check("active", 16'(act), 16'(m_open));
         check("line_count", 16'(cnt), 16'(m_cnt));
         check("error", 16'(err), 16'(m_err));
      end
   end

   typedef struct {int k; int rq; int ac; int cn; int er;} pin_t;
   pin_t pins[$];

   function automatic void pin(input int k, input int rq, input int ac, input int cn, input int er);
      pin_t p;
      p = '{k, rq, ac, cn, er};
      pins.push_back(p);
   endfunction

   function automatic bit has(input int q[$], input int v);
      foreach (q[i]) if (q[i] == v) return 1'b1;
      return 1'b0;
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b1; strobe = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; strobe = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      check("rst_request", 16'(req), 16'd0);
      check("rst_active", 16'(act), 16'd0);
      check("rst_count", 16'(cnt), 16'd0);
      check("rst_error", 16'(err), 16'd0);
   endtask

   task automatic play(input int n, input int st[$], input int sb[$], input int rs[$]);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         start  = has(st, k);
         strobe = has(sb, k);
         rst    = has(rs, k);
         @(negedge clk);
         foreach (pins[i]) begin
            if (pins[i].k == k) begin
               if (pins[i].rq >= 0) check($sformatf("pin_req@%0d", k), 16'(req), 16'(pins[i].rq));
               if (pins[i].ac >= 0) check($sformatf("pin_act@%0d", k), 16'(act), 16'(pins[i].ac));
               if (pins[i].cn >= 0) check($sformatf("pin_cnt@%0d", k), 16'(cnt), 16'(pins[i].cn));
               if (pins[i].er >= 0) check($sformatf("pin_err@%0d", k), 16'(err), 16'(pins[i].er));
            end
         end
      end
      @(posedge clk); #1;
      start = 1'b0; strobe = 1'b0; rst = 1'b0;
      pins.delete();
   endtask

   initial begin
      // Full frame, then start pulses through the holdoff, then an accepted restart.
      do_reset();
      pin(20, 0, 1, 3, 0);
      pin(21, 1, 0, 4, 0);
      pin(22, 0, 0, 4, 0);
      pin(29, 0, 0, 4, 0);
      pin(30, 0, 0, 4, 0);
      pin(31, 0, 1, 0, 0);
      play(40, {0, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30}, {5, 10, 15, 20, 25}, {-1});

      // Gap timeout after two lines.
      do_reset();
      pin(29, 0, 1, 2, 0);
      pin(30, 1, 0, 2, 1);
      pin(31, 0, 0, 2, 1);
      play(34, {0}, {5, 10}, {-1});

      // Premature restart with coincident strobe, then a clean restart clears the error.
      do_reset();
      pin(8, 0, 1, 1, 0);
      pin(9, 1, 0, 1, 1);
      pin(10, 0, 0, 1, 1);
      pin(17, 0, 0, 1, 1);
      pin(19, 0, 1, 0, 0);
      play(22, {0, 8, 18}, {5, 8}, {-1});

      // Reset mid-frame: no request, strobes in IDLE not counted.
      do_reset();
      pin(12, 0, 1, 2, 0);
      pin(13, 0, 0, 0, 0);
      pin(20, 0, 0, 0, 0);
      pin(22, 0, 0, 0, 0);
      play(30, {0}, {5, 10, 14, 16}, {12});

      // Back-to-back frames: start in last holdoff cycle ignored, next one accepted.
      do_reset();
      pin(5, 1, 0, 4, 0);
      pin(13, 0, 0, 4, 0);
      pin(14, 0, 0, 4, 0);
      pin(15, 0, 1, 0, 0);
      pin(20, 1, 0, 4, 0);
      play(24, {0, 13, 14}, {1, 2, 3, 4, 16, 17, 18, 19}, {-1});

      // Timeout with no strobes at all.
      do_reset();
      pin(19, 0, 1, 0, 0);
      pin(20, 1, 0, 0, 1);
      play(24, {0}, {-1}, {-1});

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
